// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial Moore sequence detector among
// N_REQ requesters. A granted frame is latched, the detector is cleared,
// the frame is shifted out LSB first, and det_out pulses are counted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for any req
// S_GRANT | round-robin pick, latch frame, pulse ack (or back to idle)
// S_CLEAR | det_rst high for one cycle, match count cleared
// S_FEED  | one frame bit per cycle on det_in, count det_out from bit 1
// S_DRAIN | det_out reflects the last bit, final count update
// S_DONE  | res_valid pulse, res_id/res_cnt hold the result
module seq_det_sched #(
   parameter int N_REQ   = 4,
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*MAX_LEN-1:0]    req_data,
   input  logic [N_REQ*LEN_W-1:0]      req_len,
   output logic [N_REQ-1:0]            ack,
   output logic                        busy,
   output logic                        det_rst,
   output logic                        det_in,
   input  logic                        det_out,
   output logic                        res_valid,
   output logic [$clog2(N_REQ)-1:0]    res_id,
   output logic [LEN_W-1:0]            res_cnt
);

   localparam int ID_W = $clog2(N_REQ);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_CLEAR = 3'd2,
      S_FEED  = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [MAX_LEN-1:0]   data_q, data_d;
   logic [LEN_W-1:0]     rem_q, rem_d;
   logic [LEN_W-1:0]     cnt_q, cnt_d;
   logic                 first_q, first_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic                 res_valid_q, res_valid_d;
   logic [ID_W-1:0]      res_id_q, res_id_d;
   logic [LEN_W-1:0]     res_cnt_q, res_cnt_d;

   logic                 grant_vld;
   logic [ID_W-1:0]      grant_idx;
   logic [LEN_W-1:0]     sel_len;
   logic [LEN_W-1:0]     sel_len_clamp;
   logic [MAX_LEN-1:0]   sel_data;
   logic [N_REQ-1:0]     ack_c;
   logic                 det_rst_c;
   logic                 det_in_c;
   logic [LEN_W-1:0]     det_out_inc;

   // Round-robin search starting at rr_ptr, first asserted req wins
   always_comb begin
      int              cand;
      logic [ID_W-1:0] cand_idx;
      cand      = 0;
      cand_idx  = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         cand_idx = ID_W'(cand);
         if (!grant_vld && req[cand_idx]) begin
            grant_vld = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   assign sel_len       = req_len[int'(grant_idx)*LEN_W +: LEN_W];
   assign sel_data      = req_data[int'(grant_idx)*MAX_LEN +: MAX_LEN];
   // Oversized lengths are clamped so the down-counter never runs past the frame
   assign sel_len_clamp = (sel_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : sel_len;
   assign det_out_inc   = {{(LEN_W-1){1'b0}}, det_out};

   // Next-state, datapath updates and Moore-style outputs
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      data_d      = data_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      first_d     = first_q;
      id_d        = id_q;
      res_valid_d = 1'b0;
      res_id_d    = res_id_q;
      res_cnt_d   = res_cnt_q;
      ack_c       = '0;
      det_rst_c   = 1'b0;
      det_in_c    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (grant_vld) begin
               ack_c   = N_REQ'(1) << grant_idx;
               data_d  = sel_data;
               rem_d   = sel_len_clamp;
               id_d    = grant_idx;
               if (grant_idx == ID_W'(N_REQ - 1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = grant_idx + ID_W'(1);
               end
               state_d = S_CLEAR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            det_rst_c = 1'b1;
            cnt_d     = '0;
            first_d   = 1'b1;
            if (rem_q == '0) begin
               res_valid_d = 1'b1;
               res_id_d    = id_q;
               res_cnt_d   = '0;
               state_d     = S_DONE;
            end else begin
               state_d = S_FEED;
            end
         end
         S_FEED: begin
            det_in_c = data_q[0];
            data_d   = data_q >> 1;
            // det_out lags det_in by one cycle; bit 0 has no prior result
            if (!first_q) begin
               cnt_d = cnt_q + det_out_inc;
            end
            first_d = 1'b0;
            rem_d   = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            cnt_d       = cnt_q + det_out_inc;
            res_valid_d = 1'b1;
            res_id_d    = id_q;
            res_cnt_d   = cnt_q + det_out_inc;
            state_d     = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         data_q      <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b0;
         id_q        <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         data_q      <= data_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         id_q        <= id_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_cnt_q   <= res_cnt_d;
      end
   end

   // Reset dominates the combinational outputs so nothing leaks during rst
   assign ack       = rst ? '0 : ack_c;
   assign det_rst   = rst | det_rst_c;
   assign det_in    = ~rst & det_in_c;
   assign busy      = ~rst & (state_q != S_IDLE);
   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched with a non-overlapping 101 Moore detector
// modelled locally as the shared resource.
module tb_seq_det_sched;

   localparam int N_REQ   = 4;
   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [N_REQ-1:0]         req;
   logic [N_REQ*MAX_LEN-1:0] req_data;
   logic [N_REQ*LEN_W-1:0]   req_len;
   logic [N_REQ-1:0]         ack;
   logic                     busy;
   logic                     det_rst;
   logic                     det_in;
   logic                     det_out;
   logic                     res_valid;
   logic [1:0]               res_id;
   logic [LEN_W-1:0]         res_cnt;

   seq_det_sched #(.N_REQ(N_REQ), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .req_len   (req_len),
      .ack       (ack),
      .busy      (busy),
      .det_rst   (det_rst),
      .det_in    (det_in),
      .det_out   (det_out),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_cnt   (res_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Non-overlapping 101 detector: 0=idle, 1=saw 1, 2=saw 10, 3=match
   logic [1:0] d_st;
   always @(posedge clk) begin
      if (det_rst) d_st <= 2'd0;
      else begin
         case (d_st)
            2'd0: d_st <= det_in ? 2'd1 : 2'd0;
            2'd1: d_st <= det_in ? 2'd1 : 2'd2;
            2'd2: d_st <= det_in ? 2'd3 : 2'd0;
            default: d_st <= det_in ? 2'd1 : 2'd0;
         endcase
      end
   end
   assign det_out = (d_st == 2'd3);

   int res_events = 0;
   always @(negedge clk) if (res_valid) res_events <= res_events + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One requester, one frame; checks ack, detector clear, fed bits, latency and result
   task automatic run_frame(input string tag, input int id, input int len,
                            input logic [15:0] data, input int exp_cnt, input bit change_data);
      int          eff, exp_lat, req_cyc, ack_cyc, res_cyc, rst_cnt, rst_at, outside, off;
      logic [31:0] fed, mask;
      bit          got;
      eff     = (len > MAX_LEN) ? MAX_LEN : len;
      exp_lat = (eff == 0) ? 3 : eff + 4;
      mask    = (eff == 0) ? 32'd0 : ((32'd1 << eff) - 32'd1);
      @(posedge clk); #1;
      req_data[id*MAX_LEN +: MAX_LEN] = data;
      req_len[id*LEN_W +: LEN_W]      = LEN_W'(len);
      req[id]  = 1'b1;
      req_cyc  = cyc;
      got      = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (ack != '0) got = 1'b1;
      end
      chk({tag, "_ack_seen"}, 32'(got), 32'd1);
      if (!got) begin
         req[id] = 1'b0;
         return;
      end
      chk({tag, "_ack_onehot"}, 32'(ack), 32'd1 << id);
      ack_cyc = cyc;
      @(posedge clk); #1;
      req[id] = 1'b0;
      if (change_data) begin
         req_data[id*MAX_LEN +: MAX_LEN] = 16'h0000;
         req_len[id*LEN_W +: LEN_W]      = LEN_W'(16);
      end
      fed = '0; rst_cnt = 0; rst_at = -1; outside = 0; got = 1'b0; res_cyc = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         off = cyc - ack_cyc - 2;
         if (det_rst) begin
            rst_cnt++;
            rst_at = cyc;
         end
         if (off >= 0 && off < eff) fed[off] = det_in;
         else if (det_in) outside++;
         if (res_valid) begin
            got     = 1'b1;
            res_cyc = cyc;
         end
      end
      chk({tag, "_res_seen"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, 32'(res_cyc - req_cyc), 32'(exp_lat));
      chk({tag, "_res_id"}, 32'(res_id), 32'(id));
      chk({tag, "_res_cnt"}, 32'(res_cnt), 32'(exp_cnt));
      chk({tag, "_det_rst_cycles"}, 32'(rst_cnt), 32'd1);
      chk({tag, "_det_rst_pos"}, 32'(rst_at - ack_cyc), 32'd1);
      chk({tag, "_fed_bits"}, fed, {16'h0, data} & mask);
      chk({tag, "_det_in_outside"}, 32'(outside), 32'd0);
      @(negedge clk);
      chk({tag, "_res_pulse"}, 32'(res_valid), 32'd0);
      chk({tag, "_idle_after"}, 32'(busy), 32'd0);
      chk({tag, "_res_cnt_hold"}, 32'(res_cnt), 32'(exp_cnt));
   endtask

   initial begin
      int          ev0, a_cyc, idx;
      bit          got, drop;
      int          acks[$];
      int          rids[$];
      int          rcnts[$];
      int          exp_rr_cnt[4];

      rst      = 1'b1;
      req      = '0;
      req_data = '0;
      req_len  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_res_cnt", 32'(res_cnt), 32'd0);
      chk("rst_det_in", 32'(det_in), 32'd0);
      chk("rst_det_rst", 32'(det_rst), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_det_rst", 32'(det_rst), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // sent 1,0,1,0,1 -> one non-overlapping match
      run_frame("t1_single", 0, 5, 16'h0015, 1, 1'b0);
      // sent 1,0,1,1,0,1,0 -> two matches
      run_frame("t2_overlap", 2, 7, 16'h002D, 2, 1'b0);

      // req present in IDLE but gone by GRANT: no ack, back to idle
      ev0 = res_events;
      @(posedge clk); #1;
      req[3] = 1'b1;
      @(posedge clk); #1;
      req[3] = 1'b0;
      @(negedge clk);
      chk("glitch_busy_grant", 32'(busy), 32'd1);
      chk("glitch_no_ack", 32'(ack), 32'd0);
      @(negedge clk);
      chk("glitch_idle", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      #1;
      chk("glitch_no_res", 32'(res_events - ev0), 32'd0);

      run_frame("t4_len0", 2, 0, 16'hFFFF, 0, 1'b0);
      // only bits 13..15 = 1,0,1 carry a match, seen in DRAIN
      run_frame("t4_len20", 3, 20, 16'hA000, 1, 1'b0);
      run_frame("t4_len16_ones", 0, 16, 16'hFFFF, 0, 1'b0);
      // data changes to zero after ack; latched 1,0,1,1,0,1 must still give 2
      run_frame("t6_stable", 1, 6, 16'h002D, 2, 1'b1);

      // reset at FEED bit 3 of a 10-bit frame
      ev0 = res_events;
      @(posedge clk); #1;
      req_data[1*MAX_LEN +: MAX_LEN] = 16'h02AD;
      req_len[1*LEN_W +: LEN_W]      = LEN_W'(10);
      req[1] = 1'b1;
      got    = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (ack != '0) got = 1'b1;
      end
      chk("t5_ack_seen", 32'(got), 32'd1);
      a_cyc = cyc;
      @(posedge clk); #1;
      req[1] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      chk("t5_at_bit3", 32'(cyc - a_cyc), 32'd5);
      @(negedge clk);
      chk("t5_det_rst_in_rst", 32'(det_rst), 32'd1);
      chk("t5_no_ack_in_rst", 32'(ack), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_busy_after", 32'(busy), 32'd0);
      chk("t5_det_in_after", 32'(det_in), 32'd0);
      chk("t5_det_rst_after", 32'(det_rst), 32'd0);
      repeat (20) @(negedge clk);
      #1;
      chk("t5_no_res", 32'(res_events - ev0), 32'd0);
      // sent 1,0,1,1,0,1,0,1,0,1 -> three matches
      run_frame("t5_reissue", 1, 10, 16'h02AD, 3, 1'b0);

      // contention from rr_ptr=0 with all four requesting continuously
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_rr_cnt = '{1, 2, 0, 2};
      req_data[0*MAX_LEN +: MAX_LEN] = 16'h0005;
      req_len[0*LEN_W +: LEN_W]      = LEN_W'(3);
      req_data[1*MAX_LEN +: MAX_LEN] = 16'h002D;
      req_len[1*LEN_W +: LEN_W]      = LEN_W'(6);
      req_data[2*MAX_LEN +: MAX_LEN] = 16'h0000;
      req_len[2*LEN_W +: LEN_W]      = LEN_W'(4);
      req_data[3*MAX_LEN +: MAX_LEN] = 16'h0155;
      req_len[3*LEN_W +: LEN_W]      = LEN_W'(9);
      req  = 4'hF;
      drop = 1'b0;
      for (int i = 0; i < 300 && rids.size() < 8; i++) begin
         @(posedge clk); #1;
         if (drop) req = '0;
         @(negedge clk);
         if (ack != '0) begin
            idx = -1;
            for (int k = 0; k < N_REQ; k++) if (ack[k]) idx = k;
            acks.push_back(idx);
            if (acks.size() == 8) drop = 1'b1;
         end
         if (res_valid) begin
            rids.push_back(int'(res_id));
            rcnts.push_back(int'(res_cnt));
         end
      end
      req = '0;
      chk("rr_acks", 32'(acks.size()), 32'd8);
      chk("rr_results", 32'(rids.size()), 32'd8);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("rr_ack_order_%0d", k), 32'((k < acks.size()) ? acks[k] : -1), 32'(k % 4));
         chk($sformatf("rr_res_id_%0d", k), 32'((k < rids.size()) ? rids[k] : -1), 32'(k % 4));
         chk($sformatf("rr_res_cnt_%0d", k), 32'((k < rcnts.size()) ? rcnts[k] : -1),
             32'(exp_rr_cnt[k % 4]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
